// File: rtl/lct_l1a_matcher.sv
// ---------------------------------------------------------------------------
// lct_l1a_matcher
//
// Per-CFEB trigger-matching stage that feeds the CFEB trigger encoder.
// Each CFEB's pre-LCT (or CLCT) hit is delayed by a programmable latency and
// then opens a programmable match window. An L1A arriving while a CFEB's
// window is open flags that CFEB in o_l1a_match. An L1A counter and a
// no-match pulse are provided for the DAQ path.
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_rst          synchronous active-high reset
//   i_resync       TTC resync pulse
//   i_l1a          level-1 accept pulse
//   i_pre_lct[4:0] per-CFEB pre-LCT, bit i = CFEB i
//   i_clct[4:0]    per-CFEB CLCT hit
//   i_use_clct     match source select: 0 = pre-LCT, 1 = CLCT
//   i_kill[4:0]    per-CFEB disable mask
//   i_lct_l1a_dly  delay from source hit to window start (0 acts as 1)
//   i_win_len      extra window length in clocks (0 = 1-clock window)
//   o_pre_lct_out  registered, masked pre-LCT
//   o_l1a_match    per-CFEB match pulse
//   o_l1acfeb      registered L1A pulse, aligned with o_l1a_match
//   o_resync_rst   registered resync pulse
//   o_nomatch      pulse: L1A with no CFEB window open
//   o_l1a_cnt      accepted-L1A count, wraps to 0
//
// Interface timing: there is no valid/ready handshake. All inputs are
// single-clock pulses or levels sampled on every rising edge; every output
// pulse (o_l1acfeb, o_l1a_match, o_nomatch, o_resync_rst) is high for
// exactly one clock, one clock after the input edge that caused it.
// ---------------------------------------------------------------------------
module lct_l1a_matcher #(
  parameter int DLY_W = 8,
  parameter int WIN_W = 4,
  parameter int CNT_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_resync,
  input  logic             i_l1a,
  input  logic [4:0]       i_pre_lct,
  input  logic [4:0]       i_clct,
  input  logic             i_use_clct,
  input  logic [4:0]       i_kill,
  input  logic [DLY_W-1:0] i_lct_l1a_dly,
  input  logic [WIN_W-1:0] i_win_len,
  output logic [4:0]       o_pre_lct_out,
  output logic [4:0]       o_l1a_match,
  output logic             o_l1acfeb,
  output logic             o_resync_rst,
  output logic             o_nomatch,
  output logic [CNT_W-1:0] o_l1a_cnt
);

  localparam int DEPTH = 2 ** DLY_W;

  logic [4:0]            r_mem [DEPTH];
  logic [DLY_W-1:0]      r_wp;
  logic [DLY_W-1:0]      r_fill;
  logic [DLY_W-1:0]      r_dly_prev;
  logic [4:0][WIN_W-1:0] r_wcnt;

  logic [DLY_W-1:0]      w_d;
  logic [DLY_W-1:0]      w_rd;
  logic                  w_dly_chg;
  logic                  w_fill_ok;
  logic [4:0]            w_src;
  logic [4:0]            w_dlct;
  logic [4:0]            w_open;

  // Source select and kill masking happen before the buffer write, so a
  // change of either only affects entries written from now on.
  assign w_src = (i_use_clct ? i_clct : i_pre_lct) & ~i_kill;

  // A programmed delay of 0 would read the slot being written; clamp to 1.
  assign w_d = (i_lct_l1a_dly == '0) ? DLY_W'(1) : i_lct_l1a_dly;

  // The slot written D clocks ago; modulo arithmetic wraps the pointer.
  assign w_rd = r_wp - w_d;

  // A delay change makes every older entry stale at the new offset, so the
  // change clock itself is suppressed and the fill counter restarts.
  assign w_dly_chg = (i_lct_l1a_dly != r_dly_prev);
  assign w_fill_ok = (r_fill >= w_d) && !w_dly_chg;
  assign w_dlct    = w_fill_ok ? r_mem[w_rd] : 5'b00000;

  always_comb begin
    w_open = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      w_open[i] = w_dlct[i] | (r_wcnt[i] != '0);
    end
  end

  // Delay buffer: written every clock, never cleared. Stale contents are
  // hidden by the fill counter instead.
  always_ff @(posedge i_clk) begin
    r_mem[r_wp] <= w_src;
  end

  always_ff @(posedge i_clk) begin
    r_dly_prev <= i_lct_l1a_dly;
    if (i_rst) begin
      r_wp   <= '0;
      r_fill <= '0;
    end else begin
      r_wp <= r_wp + DLY_W'(1);
      if (i_resync || w_dly_chg) begin
        r_fill <= '0;
      end else if (r_fill < w_d) begin
        r_fill <= r_fill + DLY_W'(1);
      end else begin
        r_fill <= w_d;
      end
    end
  end

  // Window counters: a delayed hit (re)loads the counter, so a new hit
  // inside an open window extends it. KILL never touches these.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 5; i++) begin
      if (i_rst || i_resync) begin
        r_wcnt[i] <= '0;
      end else if (w_dlct[i]) begin
        r_wcnt[i] <= i_win_len;
      end else if (r_wcnt[i] != '0) begin
        r_wcnt[i] <= r_wcnt[i] - WIN_W'(1);
      end
    end
  end

  // Output stage. An L1A coincident with RESYNC is dropped entirely.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pre_lct_out <= '0;
      o_resync_rst  <= 1'b0;
      o_l1acfeb     <= 1'b0;
      o_l1a_match   <= '0;
      o_nomatch     <= 1'b0;
      o_l1a_cnt     <= '0;
    end else begin
      o_pre_lct_out <= i_pre_lct & ~i_kill;
      o_resync_rst  <= i_resync;
      if (i_resync) begin
        o_l1acfeb   <= 1'b0;
        o_l1a_match <= '0;
        o_nomatch   <= 1'b0;
        o_l1a_cnt   <= '0;
      end else begin
        o_l1acfeb   <= i_l1a;
        o_l1a_match <= i_l1a ? w_open : 5'b00000;
        o_nomatch   <= i_l1a & (w_open == 5'b00000);
        o_l1a_cnt   <= o_l1a_cnt + {{(CNT_W-1){1'b0}}, i_l1a};
      end
    end
  end

endmodule

// File: doc/lct_l1a_matcher.md
Name: lct_l1a_matcher

Overview:
- Per-CFEB trigger-matching stage, directly upstream of the CFEB trigger encoder.
- Produces the five-bit PRE_LCT_OUT, L1A_MATCH, L1ACFEB and RESYNC_RST signals that the encoder consumes.
- Delays each CFEB's pre-LCT (or CLCT) by a programmable latency, then opens a programmable match window. Flags every CFEB whose window is open when an L1A arrives.
- Also keeps an L1A counter and a no-match indicator for the DAQ path.

Parameters:
- DLY_W, 8: width of LCT_L1A_DLY; delay buffer depth is 2**DLY_W entries.
- WIN_W, 4: width of WIN_LEN and of the per-CFEB window counters.
- CNT_W, 24: width of L1A_CNT.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- RESYNC  in  1  TTC resync pulse.
- L1A  in  1  level-1 accept pulse.
- PRE_LCT  in  5  per-CFEB pre-LCT, bit i = CFEB i.
- CLCT  in  5  per-CFEB CLCT hit.
- USE_CLCT  in  1  match source select: 0 = PRE_LCT, 1 = CLCT.
- KILL  in  5  per-CFEB disable mask.
- LCT_L1A_DLY  in  DLY_W  delay from source hit to window start, in clocks.
- WIN_LEN  in  WIN_W  extra window length, in clocks.
- PRE_LCT_OUT  out  5  registered, masked pre-LCT.
- L1A_MATCH  out  5  per-CFEB match pulse.
- L1ACFEB  out  1  registered L1A pulse, aligned with L1A_MATCH.
- RESYNC_RST  out  1  registered resync pulse.
- NOMATCH  out  1  pulse: L1A with no CFEB matched.
- L1A_CNT  out  CNT_W  accepted-L1A count.

Behaviour:
- Reset (RST=1): all outputs 0; window counters 0; delay buffer write pointer 0; fill counter 0.
- PRE_LCT_OUT[i] <= PRE_LCT[i] & ~KILL[i]; 1-clock latency. Not affected by RESYNC.
- RESYNC_RST <= RESYNC; 1-clock latency.
- Source: SRC[i] = (USE_CLCT ? CLCT[i] : PRE_LCT[i]) & ~KILL[i].
- Delay line:
  - SRC is written each clock into a circular buffer of 2**DLY_W x 5.
  - Delayed value DLCT at clock t = SRC at clock t-D.
  - D = LCT_L1A_DLY, except LCT_L1A_DLY=0 is clamped to D=1.
  - Range of D: 1..2**DLY_W-1.
- Stale-data suppression:
  - A fill counter forces DLCT=0 until D writes have occurred since the last RST, RESYNC, or change of LCT_L1A_DLY.
  - No buffer clear is needed.
  - Fill counter saturates at D.
- Window, per CFEB:
  - If DLCT[i]=1, WCNT[i] loads WIN_LEN.
  - Else if WCNT[i]!=0, WCNT[i] decrements.
  - OPEN[i] = DLCT[i] | (WCNT[i]!=0).
  - WIN_LEN=0 gives a 1-clock window.
  - A new DLCT during an open window reloads the counter (window extends).
- Match, for an L1A at clock t:
  - At t+1: L1ACFEB=1 and L1A_MATCH[i]=OPEN[i] at t.
  - At t+1: NOMATCH = (OPEN at t == 0).
  - All three are 1-clock pulses.
  - L1A_CNT increments at t+1 and wraps at 2**CNT_W-1 -> 0.
  - Back-to-back L1As are each handled independently; a window is not consumed by a match.
- RESYNC at clock t:
  - At t+1: WCNT=0, fill counter=0, L1A_CNT=0.
  - L1A at the same clock as RESYNC is dropped: L1ACFEB, L1A_MATCH and NOMATCH stay 0 and L1A_CNT is not incremented.
  - SRC still written, but suppressed by the fill counter.
- RST mid-operation has the same effect as RESYNC plus all outputs cleared.
- KILL asserted while a window is open does not close it; KILL only gates new SRC entries.
- USE_CLCT or KILL changes take effect on the next SRC write; delayed data already in the buffer is unaffected.

Test Plan:
- DLY=10, WIN_LEN=3, PRE_LCT=5'b00100 at t0, L1A at t0+12 -> L1A_MATCH=5'b00100, L1ACFEB=1 at t0+13, NOMATCH=0, L1A_CNT=1.
- Same setup, L1A at t0+9 or t0+14 -> L1A_MATCH=0, NOMATCH=1 at next clock; L1A at t0+10 and t0+13 -> both match.
- USE_CLCT=1, CLCT=5'b10001, PRE_LCT=5'b01110, KILL=5'b00001, DLY=5, WIN_LEN=0, L1A at t0+5 -> L1A_MATCH=5'b10000; PRE_LCT_OUT=5'b01110 at t0+1.
- PRE_LCT=5'b11111 continuous, RESYNC pulse, L1A on same clock -> RESYNC_RST=1, no L1ACFEB, L1A_CNT=0. Later L1A before DLY clocks have elapsed -> NOMATCH=1; after DLY clocks -> 5'b11111.
- LCT_L1A_DLY=0 -> behaves as DLY=1. Change DLY 20->4 mid-run -> no match from stale entries for 4 clocks.
- Preload L1A_CNT to 2**24-1 via L1As (or force) -> next L1A gives L1A_CNT=0. RST mid-window -> all outputs 0 next clock.
